bcd_counter_n: RTL
==================

Name: bcd_counter_n

Overview:
- Parametrised, fully synchronous N-digit BCD counter. Successor to the single-digit, clock-cascaded BCD counter.
- Adds up/down counting, parallel load with BCD validation, count enable, and an optional saturate mode.
- Produces a registered carry/borrow pulse. Stages cascade by driving the next stage's en from carry_out, with all stages on the same clk; there is no ripple clocking.
- Used for display counters, timers and event tallies in the design.

Parameters:
- DIGITS, 2, number of BCD digits; legal range 1..8.
- SATURATE, 0, 0 = wrap at terminal value; 1 = hold at terminal value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- Clear  input  1  synchronous active-high reset.
- en  input  1  count enable; one step per clock while high.
- up_dn  input  1  1 = count up, 0 = count down; sampled only when en=1.
- load  input  1  parallel load request.
- load_val  input  4*DIGITS  load value; digit i occupies bits [4i+3:4i]; digit 0 is least significant.
- count  output  4*DIGITS  registered BCD count, same digit packing as load_val.
- carry_out  output  1  registered one-cycle pulse on a terminal-value step (carry when counting up, borrow when counting down).
- load_err  output  1  registered, sticky flag set when a load is rejected.

Behaviour:
- Reset: Clear=1 at a rising edge forces count=0, carry_out=0, load_err=0. Clear overrides every other input.
  - Clear asserted mid-count takes effect at the next edge.
  - Counting resumes from 0 on the first edge with Clear=0.
- Priority per edge: Clear > load > en. When en=0 and load=0, count holds and carry_out=0.
- Load, valid value (load=1, every digit of load_val <= 9):
  - count <= load_val, load_err <= 0, carry_out <= 0.
  - en is ignored that cycle.
- Load, invalid value (any digit of load_val in 10..15):
  - count holds, load_err <= 1, carry_out <= 0.
  - load_err stays high until Clear or the next valid load.
- Count up (en=1, up_dn=1):
  - Digit i increments when all digits below i equal 9.
  - A digit that reaches 9 and is stepped becomes 0.
- Count down (en=1, up_dn=0):
  - Digit i decrements when all digits below i equal 0.
  - A digit at 0 that is stepped becomes 9.
- Terminal values: up terminal = all digits 9; down terminal = all digits 0.
- Stepping at a terminal value:
  - SATURATE=0: count wraps (all-9 -> all-0 going up; all-0 -> all-9 going down) and carry_out=1 for exactly that one cycle, coincident with the wrapped count.
  - SATURATE=1: count holds at the terminal value and carry_out=1 for each cycle en stays high at the terminal value.
- Latency:
  - One clock from input to count.
  - carry_out is registered in the same edge that updates count.
  - Nothing is combinational from inputs to outputs.
- Direction change: up_dn may change on any cycle; the new direction applies at the next enabled edge with no dead cycle.
- Cascading: the next stage's en = this stage's carry_out, with both stages on the same clk. The upper stage steps on the edge after the lower stage wraps, so a cascade of k stages has a skew of k-1 clocks.
- Invariants:
  - No register ever holds a non-BCD digit (10..15) after reset.
  - carry_out is never high in a cycle where load or Clear was applied.

Test Plan:
1. DIGITS=2, SATURATE=0: Clear=1 for 1 cycle, then en=1, up_dn=1 for 100 cycles -> count goes 00,01..09,10..99,00; carry_out high only in the cycle count=00 after 99; load_err=0 throughout.
2. Down wrap: load_val=8'h03, load=1 for one cycle; then en=1, up_dn=0 for 5 cycles -> count 03,02,01,00,99,98; carry_out high only with the 99.
3. Load validation: load_val=8'h4A, load=1 -> count unchanged, load_err=1. Then load_val=8'h57, load=1 -> count=57, load_err=0. Load and en together -> load wins, no step.
4. SATURATE=1, DIGITS=3: load 999, en=1, up_dn=1 for 3 cycles -> count stays 999, carry_out=1 on all 3 cycles. Then up_dn=0 -> 998, carry_out=0.
5. Reset mid-count: counting up at 47, Clear=1 with en=1 -> next edge count=00, carry_out=0. Clear=0 -> 01 on the following edge. Repeat with Clear held 20 cycles -> count held at 00.
6. Cascade: two DIGITS=1 instances, upper en = lower carry_out, 150 cycles up from reset -> {upper,lower} tracks decimal 0..99 with a 1-cycle skew at each tens rollover. Checker confirms no non-BCD digit ever appears.

Source files
------------

// File: rtl/bcd_counter_n.sv
// Fully synchronous N-digit BCD up/down counter. It supports validated parallel load,
// an optional saturate mode, and a registered carry/borrow pulse for same-clock cascading.
module bcd_counter_n #(
    parameter int DIGITS   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  Clear,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry_out,
    output logic                  load_err
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]      count_q, count_d;
    logic [W-1:0]      inc_val, dec_val;
    logic              carry_q, carry_d;
    logic              load_err_q, load_err_d;
    logic [DIGITS-1:0] is_nine, is_zero, load_ok, step_up, step_dn;
    logic              up_term, dn_term;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit         = count_q[4*gi +: 4];
            assign is_nine[gi]   = (digit == 4'd9);
            assign is_zero[gi]   = (digit == 4'd0);
            assign load_ok[gi]   = (load_val[4*gi +: 4] <= 4'd9);

            // A digit steps only when every lower digit is at its rollover value.
            if (gi == 0) begin : g_lsd
                assign step_up[gi] = 1'b1;
                assign step_dn[gi] = 1'b1;
            end else begin : g_upper
                assign step_up[gi] = &is_nine[gi-1:0];
                assign step_dn[gi] = &is_zero[gi-1:0];
            end

            assign inc_val[4*gi +: 4] = !step_up[gi] ? digit :
                                        (is_nine[gi] ? 4'd0 : digit + 4'd1);
            assign dec_val[4*gi +: 4] = !step_dn[gi] ? digit :
                                        (is_zero[gi] ? 4'd9 : digit - 4'd1);
        end
    endgenerate

    assign up_term = &is_nine;
    assign dn_term = &is_zero;

    always_comb begin
        count_d    = count_q;
        carry_d    = 1'b0;
        load_err_d = load_err_q;
        if (load) begin
            if (&load_ok) begin
                count_d    = load_val;
                load_err_d = 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            // inc_val/dec_val already wrap at the terminal value; saturate just holds.
            if (up_dn) begin
                carry_d = up_term;
                if (!(SATURATE && up_term)) begin
                    count_d = inc_val;
                end
            end else begin
                carry_d = dn_term;
                if (!(SATURATE && dn_term)) begin
                    count_d = dec_val;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Clear) begin
            count_q    <= '0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign count     = count_q;
    assign carry_out = carry_q;
    assign load_err  = load_err_q;

endmodule
